// File: rtl/candy_ctrl_seq.sv
// candy_ctrl_seq: multi-stage instruction sequencer with per-stage completion waits,
// wait timeout, single-step / halt control and optional performance counters.
// Optional feature macro: CANDY_SEQ_PERF_EN enables the inst_cnt / stall_cnt counters;
// without it both counter outputs are tied to zero.
module candy_ctrl_seq #(
    parameter int unsigned        NSTAGE    = 4,
    parameter logic [NSTAGE-1:0]  WAIT_MASK = 4'b0010,
    parameter int unsigned        TMO_W     = 8,
    localparam int unsigned       SW        = $clog2(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              halt_req,
    input  logic              step_mode,
    input  logic              step,
    input  logic              err_clr,
    input  logic [NSTAGE-1:0] stage_done,
    output logic [NSTAGE-1:0] stage_en,
    output logic [SW-1:0]     stage_idx,
    output logic              inst_done,
    output logic              busy,
    output logic              halted,
    output logic              tmo_err,
    output logic [31:0]       inst_cnt,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted,
        StErr
    } state_e;

    localparam logic [SW-1:0] LastStage = SW'(NSTAGE - 1);
    // Last count value before saturation; a miss on this cycle saturates and faults.
    localparam logic [TMO_W-1:0] TmoLast = {{(TMO_W - 1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [NSTAGE-1:0] stage_en_q, stage_en_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              inst_done_q, inst_done_d;

    logic cur_wait;
    logic cur_done;
    logic waiting;
    logic stage_adv;
    logic at_last;
    logic tmo_hit;

    // Decode the active stage's wait requirement and completion.
    always_comb begin
        cur_wait  = WAIT_MASK[stage_q];
        cur_done  = stage_done[stage_q];
        waiting   = (state_q == StRun) && cur_wait && !cur_done;
        stage_adv = (state_q == StRun) && (!cur_wait || cur_done);
        at_last   = (stage_q == LastStage);
        tmo_hit   = waiting && (tmo_q == TmoLast);
    end

    // State and registered outputs; async reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            stage_en_q  <= '0;
            tmo_q       <= '0;
            inst_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            stage_en_q  <= stage_en_d;
            tmo_q       <= tmo_d;
            inst_done_q <= inst_done_d;
        end
    end

    // Next-state: stage sequencing, boundary decisions, timeout and error recovery.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        tmo_d       = tmo_q;
        inst_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StRun;
                    stage_d = '0;
                    tmo_d   = '0;
                end
            end
            StRun: begin
                if (stage_adv) begin
                    // done on the saturating cycle still advances
                    tmo_d = '0;
                    if (at_last) begin
                        inst_done_d = 1'b1;
                        stage_d     = '0;
                        if (step_mode || halt_req) begin
                            state_d = StHalted;
                        end else if (!run) begin
                            state_d = StIdle;
                        end
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else if (tmo_hit) begin
                    state_d = StErr;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StHalted: begin
                // step wins over halt_req / step_mode
                if (step || (run && !step_mode && !halt_req)) begin
                    state_d = StRun;
                    stage_d = '0;
                    tmo_d   = '0;
                end
            end
            StErr: begin
                if (err_clr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d != StRun) begin
            stage_d = '0;
        end
        // Enable derived from the same next index so the two never disagree.
        stage_en_d = (state_d == StRun) ? (NSTAGE'(1) << stage_d) : '0;
    end

    // Output decode from registered state.
    always_comb begin
        stage_en  = stage_en_q;
        stage_idx = stage_q;
        inst_done = inst_done_q;
        busy      = (state_q == StRun);
        halted    = (state_q == StHalted);
        tmo_err   = (state_q == StErr);
    end

`ifdef CANDY_SEQ_PERF_EN
    logic [31:0] inst_cnt_q;
    logic [31:0] stall_cnt_q;

    // Retirements counted on the edge that raises inst_done; stalls per waiting RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (inst_done_d) begin
                inst_cnt_q <= inst_cnt_q + 32'd1;
            end
            if (waiting) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign inst_cnt  = inst_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign inst_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule
